// File: rtl/fifo_burst_sched.sv
// FIFO burst scheduler: issues fixed-length bursts above a fill threshold and
// drains the FIFO residue through clipped tail bursts on line/frame tail events.
module fifo_burst_sched #(
    parameter int unsigned      CW      = 10,
    parameter int unsigned      LSIZE   = 9,
    parameter int unsigned      TO_W    = 24,
    parameter logic [TO_W-1:0]  TIMEOUT = TO_W'(24'hFFF000),
    parameter int unsigned      ECW     = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             enable,
    input  logic             f_rst_status,
    input  logic [CW-1:0]    count,
    input  logic             fifo_empty,
    input  logic             line_tail,
    input  logic             frame_tail,
    input  logic [1:0]       cfg_mode,
    input  logic [CW-1:0]    cfg_threshold,
    input  logic [LSIZE-1:0] cfg_burst_len,
    output logic             req,
    output logic             req_tail,
    output logic [LSIZE-1:0] req_len,
    input  logic             resp,
    input  logic             done,
    output logic             burst_done,
    output logic             tail_done,
    output logic             rst_chain,
    output logic             busy,
    output logic             err_timeout,
    output logic [ECW-1:0]   err_cnt
);

    localparam int unsigned MW = (CW > LSIZE) ? CW : LSIZE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_DONE,
        S_FSH,
        S_TIME_ERR,
        S_RESET_CHAIN
    } state_e;

    state_e            state_q, state_d;
    logic              tail_pend_q, tail_pend_d;
    logic              tail_burst_q, tail_burst_d;
    logic [TO_W-1:0]   wd_q, wd_d;
    logic [LSIZE-1:0]  req_len_q, req_len_d;
    logic [ECW-1:0]    err_cnt_q, err_cnt_d;
    logic              err_to_q, err_to_d;
    logic              req_q, req_tail_q, burst_done_q, tail_done_q, rst_chain_q, busy_q;

    logic              tail_evt_c;
    logic              wd_hit_c;
    logic              tail_done_c;
    logic [MW-1:0]     cnt_w_c, len_w_c;
    logic [LSIZE-1:0]  tail_len_c;

    // Tail length clipped to the residue; compared at full width so large counts keep cfg_burst_len.
    assign cnt_w_c    = MW'(count);
    assign len_w_c    = MW'(cfg_burst_len);
    assign tail_len_c = LSIZE'((cnt_w_c < len_w_c) ? cnt_w_c : len_w_c);

    assign tail_evt_c = enable && ((cfg_mode[0] && line_tail) || (cfg_mode[1] && frame_tail));
    assign wd_hit_c   = (TIMEOUT != '0) && ((wd_q + TO_W'(1)) == TIMEOUT);

    // Next-state and next-register computation.
    always_comb begin
        state_d      = state_q;
        tail_pend_d  = tail_pend_q;
        tail_burst_d = tail_burst_q;
        req_len_d    = req_len_q;
        err_cnt_d    = err_cnt_q;
        err_to_d     = err_to_q;
        tail_done_c  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    if (tail_pend_q && (count == '0)) begin
                        tail_done_c = 1'b1;
                        tail_pend_d = 1'b0;
                    end else if (tail_pend_q && !fifo_empty) begin
                        state_d      = S_REQ;
                        tail_burst_d = 1'b1;
                        req_len_d    = tail_len_c;
                    end else if ((count > cfg_threshold) && !fifo_empty) begin
                        state_d      = S_REQ;
                        tail_burst_d = 1'b0;
                        req_len_d    = cfg_burst_len;
                    end
                end
            end
            S_REQ: begin
                if (wd_hit_c)           state_d = S_TIME_ERR;
                else if (resp && done)  state_d = S_FSH;
                else if (resp)          state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (wd_hit_c)           state_d = S_TIME_ERR;
                else if (done)          state_d = S_FSH;
            end
            S_FSH:                      state_d = S_IDLE;
            S_TIME_ERR: begin
                state_d     = S_RESET_CHAIN;
                tail_pend_d = 1'b0;
            end
            S_RESET_CHAIN: begin
                if (fifo_empty)         state_d = S_IDLE;
            end
            default:                    state_d = S_IDLE;
        endcase

        // A new tail event merges with any pending one.
        if (tail_evt_c) tail_pend_d = 1'b1;

        wd_d = ((state_q == S_REQ) || (state_q == S_WAIT_DONE)) ? (wd_q + TO_W'(1)) : '0;

        if (state_d == S_TIME_ERR) begin
            err_to_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ECW'(1);
        end

        // Frame restart abandons everything except the error history.
        if (f_rst_status) begin
            state_d      = S_IDLE;
            tail_pend_d  = 1'b0;
            tail_burst_d = 1'b0;
            wd_d         = '0;
            req_len_d    = req_len_q;
            tail_done_c  = 1'b0;
            err_to_d     = err_to_q;
            err_cnt_d    = err_cnt_q;
        end
    end

    // State and output registers; outputs decode the next state.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tail_pend_q  <= 1'b0;
            tail_burst_q <= 1'b0;
            wd_q         <= '0;
            req_len_q    <= '0;
            err_cnt_q    <= '0;
            err_to_q     <= 1'b0;
            req_q        <= 1'b0;
            req_tail_q   <= 1'b0;
            burst_done_q <= 1'b0;
            tail_done_q  <= 1'b0;
            rst_chain_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tail_pend_q  <= tail_pend_d;
            tail_burst_q <= tail_burst_d;
            wd_q         <= wd_d;
            req_len_q    <= req_len_d;
            err_cnt_q    <= err_cnt_d;
            err_to_q     <= err_to_d;
            req_q        <= (state_d == S_REQ);
            req_tail_q   <= (state_d == S_REQ) && tail_burst_d;
            burst_done_q <= (state_d == S_FSH) && !tail_burst_d;
            tail_done_q  <= tail_done_c;
            rst_chain_q  <= (state_d == S_TIME_ERR);
            busy_q       <= (state_d != S_IDLE);
        end
    end

    assign req         = req_q;
    assign req_tail    = req_tail_q;
    assign req_len     = req_len_q;
    assign burst_done  = burst_done_q;
    assign tail_done   = tail_done_q;
    assign rst_chain   = rst_chain_q;
    assign busy        = busy_q;
    assign err_timeout = err_to_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: doc/fifo_burst_sched.md
Name: fifo_burst_sched

Overview:
- Parametrised, runtime-configurable FIFO burst scheduler for the VDMA write/read data paths.
- Watches the FIFO fill count and issues burst requests of a configurable length to the AXI master when the count exceeds a threshold.
- On line/frame tail events it drains the FIFO residue through as many clipped tail bursts as needed.
- Provides a working timeout watchdog with chain reset and error counters.

Parameters:
- CW, 10: width of count, cfg_threshold.
- LSIZE, 9: width of burst length fields.
- TO_W, 24: timeout counter width.
- TIMEOUT, 24'hFFF000: cycles in REQ/WAIT_DONE before error; 0 disables the watchdog.
- ECW, 8: width of err_cnt.

Ports:
- clock  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  allows new bursts and tail capture.
- f_rst_status  in  1  synchronous flush (frame restart).
- count  in  CW  FIFO fill level.
- fifo_empty  in  1  FIFO empty flag.
- line_tail  in  1  end-of-line pulse.
- frame_tail  in  1  end-of-frame pulse.
- cfg_mode  in  2  tail source: 0 none, 1 line, 2 frame, 3 both.
- cfg_threshold  in  CW  burst trigger level (strict >).
- cfg_burst_len  in  LSIZE  normal burst length; must be ≥1.
- req  out  1  burst request, level.
- req_tail  out  1  qualifies req as a tail burst.
- req_len  out  LSIZE  length of current request.
- resp  in  1  request accepted.
- done  in  1  burst finished.
- burst_done  out  1  1-cycle pulse per normal burst.
- tail_done  out  1  1-cycle pulse when tail drain is complete.
- rst_chain  out  1  1-cycle pulse on timeout.
- busy  out  1  high whenever state is not IDLE.
- err_timeout  out  1  sticky timeout flag.
- err_cnt  out  ECW  saturating timeout count.

Behaviour:
- Reset (rst=1): state IDLE. req, req_tail, burst_done, tail_done, rst_chain, busy, err_timeout are 0. req_len=0, err_cnt=0, tail_pend=0, watchdog counter=0.
- All outputs are registered and decoded from the next state, so they reflect the new state in the cycle after the transition decision.
- tail_pend:
  - Set when enable && ((cfg_mode[0] && line_tail) || (cfg_mode[1] && frame_tail)).
  - Set in any state; a second event while already pending merges with it (no queueing).
- FSM states: IDLE, REQ, WAIT_DONE, FSH, TIME_ERR, RESET_CHAIN.
- IDLE, evaluated in priority order, all requiring enable:
  1. tail_pend && count==0 → tail_done pulse next cycle, tail_pend cleared, stay IDLE.
  2. tail_pend && !fifo_empty → REQ, req_tail=1, req_len = min(count, cfg_burst_len) truncated to LSIZE.
  3. count > cfg_threshold && !fifo_empty → REQ, req_tail=0, req_len=cfg_burst_len.
  - req_len is sampled on entry to REQ and held until the next REQ entry.
  - With enable=0 the block stays in IDLE; tail_pend is held.
- REQ:
  - req=1 until resp is sampled high.
  - resp && done in the same cycle → FSH.
  - resp alone → WAIT_DONE.
- WAIT_DONE: done → FSH. done seen in IDLE is ignored.
- FSH:
  - Pulses burst_done if !req_tail; a tail burst pulses nothing here.
  - Returns to IDLE, which re-evaluates. Tail drain therefore repeats until count==0, then tail_done fires through rule 1.
  - Minimum turnaround: 1 IDLE cycle between bursts.
- Watchdog:
  - Counter cleared on REQ entry; increments each cycle in REQ/WAIT_DONE.
  - When the counter reaches TIMEOUT (TIMEOUT≠0) → TIME_ERR. Timeout has priority over a simultaneous resp/done.
- TIME_ERR (1 cycle):
  - rst_chain=1, err_timeout←1, err_cnt increments, saturating at all-ones.
  - tail_pend cleared; no done pulses.
  - Next state RESET_CHAIN.
- RESET_CHAIN: stays until fifo_empty, then IDLE.
- f_rst_status (when rst=0):
  - Next state IDLE, tail_pend cleared, watchdog cleared.
  - req/req_tail/pulses are 0 next cycle.
  - err_timeout and err_cnt are kept; only rst clears them.
  - An in-flight burst is abandoned; a later done is ignored.
- Width rule: the min() comparison is done at max(CW, LSIZE) bits. If count ≥ 2^LSIZE, the compare uses full width, so req_len=cfg_burst_len.

Test Plan:
- Basic burst: cfg_threshold=200, cfg_burst_len=100, count 150→201. Required: req high 2 cycles after count=201 with req_len=100, req_tail=0. resp after 3 cycles drops req. done then produces a burst_done pulse 2 cycles later and busy falls.
- Tail drain: cfg_mode=1, cfg_burst_len=100, line_tail pulse with count=230; the bench decrements count by each granted length. Required: tail requests of length 100, 100, 30, each with req_tail=1, then count=0 and a single tail_done pulse, with no burst_done pulses.
- Tail during burst: line_tail arrives while in WAIT_DONE (cfg_mode=3). Required: the burst completes with burst_done, and the next request is a tail request of length min(count, len).
- Mode mask: cfg_mode=2, line_tail pulses with count=50. Required: no request and no tail_done. A frame_tail pulse then gives a 50-length tail request.
- Timeout: TIMEOUT=16, resp never asserted. Required: req high for 16 cycles, then a 1-cycle rst_chain pulse, err_timeout=1, err_cnt=1. The block stays busy until fifo_empty=1, then returns to IDLE.
- Flush: f_rst_status asserted in WAIT_DONE with tail_pend=1. Required: IDLE next cycle, no pulses, tail_pend cleared, a late done ignored, and err_cnt unchanged.
